stream_fifo: RTL and testbench

Parametrised synchronous FIFO with a valid/ready stream interface on both sides, registered first-word-fall-through output, occupancy count, programmable almost-full threshold and synchronous flush. It buffers score and result words between Smith-Waterman pipeline stages and the host-side interface logic. It is the next-generation replacement for the fixed-depth, flag-only FIFO: it has explicit empty/backpressure signalling and edge-independent read handshaking.

---
 rtl/stream_fifo.sv | 136 +++++++++++++
 tb/tb_stream_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with valid/ready on both sides.
// The head word sits in a registered first-word-fall-through slot.
// The FIFO also keeps an occupancy count, a programmable almost-full flag
// and a synchronous flush.
// Optional feature macro: STREAM_FIFO_ERR_EN compiles in the sticky overflow
// flag and its err_clr clear; without it overflow is tied low.
module stream_fifo #(
    parameter int    WIDTH     = 48,
    parameter int    DEPTH     = 16,
    parameter int    ADDR_BITS = $clog2(DEPTH),
    parameter int    AFULL_LVL = DEPTH - 2,
    parameter string MEM_OPT   = "m20k,no_rw_check"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    input  logic                 err_clr
);

    localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0] CNT_DEPTH = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_AFULL = (ADDR_BITS+1)'(AFULL_LVL);

    // The RAM holds every entry, including the head; out_data is a copy of mem[rd_ptr]
    (* ramstyle = MEM_OPT *) logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS-1:0] rd_next;
    logic [ADDR_BITS:0]   count_next;
    logic                 push;
    logic                 pop;
    logic                 wr_en;

    assign in_ready = ~full;
    assign push     = in_valid && !full;
    assign pop      = out_valid && out_ready;
    assign wr_en    = push && !flush && rst;
    assign rd_next  = rd_ptr + 1'b1;

    // Next occupancy; flush and reset both drop the count to zero
    always_comb begin
        count_next = count;
        if (!rst || flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage write port, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and head register: refill on pop from RAM, or bypass in_data when RAM has no successor
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
                if (count > CNT_ONE) begin
                    out_data  <= mem[rd_next];
                    out_valid <= 1'b1;
                end else if (push) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (!out_valid && push) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end
        end
    end

    // Registered occupancy and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == CNT_DEPTH);
            almost_full <= (count_next >= CNT_AFULL);
        end
    end

`ifdef STREAM_FIFO_ERR_EN
    // Sticky overflow: a refused write sets it, err_clr clears it, set wins a tie
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (err_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a table of fill/drain vectors, then
// hand-written sequences checked against a queue reference.
module tb_stream_fifo;

    localparam int WIDTH = 48;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;
`ifdef STREAM_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             err_clr;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] q [$];
    logic             ovf_m = 1'b0;

    always #5 clk = ~clk;

    stream_fifo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .err_clr(err_clr)
    );

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        int               e_count;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic             e_full;
        logic             e_afull;
        logic             e_empty;
    } vec_t;

    vec_t tbl [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        int n;
        n = q.size();
        check({tag, " count"}, 64'(count), 64'(n));
        check({tag, " empty"}, 64'(empty), 64'(n == 0));
        check({tag, " full"}, 64'(full), 64'(n == DEPTH));
        check({tag, " almost_full"}, 64'(almost_full), 64'(n >= AFULL));
        check({tag, " in_ready"}, 64'(in_ready), 64'(n != DEPTH));
        check({tag, " out_valid"}, 64'(out_valid), 64'(n != 0));
        check({tag, " overflow"}, 64'(overflow), 64'(ovf_m));
        if (n != 0) check({tag, " out_data"}, 64'(out_data), 64'(q[0]));
    endtask

    // One clock with the reference queue updated from the pre-edge state
    task automatic cyc(input string tag, input logic fl, input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic ec);
        bit do_push;
        bit do_pop;
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy; err_clr = ec;
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        if (!rst) ovf_m = 1'b0;
        else if (ERR_EN && iv && q.size() == DEPTH) ovf_m = 1'b1;
        else if (ec) ovf_m = 1'b0;
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        tick();
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && q.size() > 0; i++) cyc(tag, 0, 0, '0, 1, 0);
    endtask

    initial begin
        rst = 1'b0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0; err_clr = 0;
        tick();
        tick();
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset count", 64'(count), 64'd0);
        check("reset empty", 64'(empty), 64'd1);
        check("reset full", 64'(full), 64'd0);
        check("reset almost_full", 64'(almost_full), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        rst = 1'b1;
        tick();

        // Fill 0x1..0x10 with the consumer stalled, then drain in order
        for (int i = 0; i < 16; i++) begin
            tbl[i].iv = 1'b1;       tbl[i].d = WIDTH'(i + 1); tbl[i].ordy = 1'b0;
            tbl[i].e_count = i + 1; tbl[i].e_valid = 1'b1;    tbl[i].e_data = WIDTH'(1);
            tbl[i].e_full = (i == 15); tbl[i].e_afull = (i + 1 >= 14); tbl[i].e_empty = 1'b0;
        end
        for (int j = 1; j <= 16; j++) begin
            tbl[15+j].iv = 1'b0;        tbl[15+j].d = '0;       tbl[15+j].ordy = 1'b1;
            tbl[15+j].e_count = 16 - j; tbl[15+j].e_valid = (j < 16);
            tbl[15+j].e_data = WIDTH'(j + 1);
            tbl[15+j].e_full = 1'b0; tbl[15+j].e_afull = (16 - j >= 14); tbl[15+j].e_empty = (j == 16);
        end
        for (int v = 0; v < 32; v++) begin
            in_valid = tbl[v].iv; in_data = tbl[v].d; out_ready = tbl[v].ordy;
            tick();
            check($sformatf("vec%0d count", v), 64'(count), 64'(tbl[v].e_count));
            check($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(tbl[v].e_valid));
            if (tbl[v].e_valid) check($sformatf("vec%0d out_data", v), 64'(out_data), 64'(tbl[v].e_data));
            check($sformatf("vec%0d full", v), 64'(full), 64'(tbl[v].e_full));
            check($sformatf("vec%0d in_ready", v), 64'(in_ready), 64'(!tbl[v].e_full));
            check($sformatf("vec%0d almost_full", v), 64'(almost_full), 64'(tbl[v].e_afull));
            check($sformatf("vec%0d empty", v), 64'(empty), 64'(tbl[v].e_empty));
        end
        in_valid = 0; out_ready = 0;

        // Continuous push+pop, occupancy 1
        for (int i = 0; i < 100; i++) cyc("stream1", 0, 1, WIDTH'(48'h100 + i), 1, 0);
        drain("stream1 drain");

        // Continuous push+pop at occupancy 3, head refilled from RAM across wrap
        for (int i = 0; i < 3; i++) cyc("stream3 fill", 0, 1, WIDTH'(48'h200 + i), 0, 0);
        for (int i = 3; i < 43; i++) cyc("stream3", 0, 1, WIDTH'(48'h200 + i), 1, 0);
        drain("stream3 drain");

        // Full with simultaneous push+pop: pop happens, push refused
        for (int i = 0; i < DEPTH; i++) cyc("full fill", 0, 1, WIDTH'(48'h400 + i), 0, 0);
        cyc("full push+pop", 0, 1, 48'h4FF, 1, 0);
        cyc("err_clr", 0, 0, '0, 0, 1);
        cyc("refill", 0, 1, 48'h4A0, 0, 0);
        cyc("set beats clr", 0, 1, 48'h4A1, 0, 1);
        cyc("clr after tie", 0, 0, '0, 0, 1);
        drain("full drain");

        // Flush with a concurrent push discards everything
        for (int i = 0; i < 5; i++) cyc("flush fill", 0, 1, WIDTH'(48'h500 + i), 0, 0);
        cyc("flush", 1, 1, 48'h55, 1, 0);
        cyc("after flush push", 0, 1, 48'hAA, 0, 0);
        drain("flush drain");

        // Reset mid-operation with a pop pending
        for (int i = 0; i < 9; i++) cyc("rst fill", 0, 1, WIDTH'(48'h600 + i), 0, 0);
        rst = 1'b0;
        cyc("mid reset", 0, 0, '0, 1, 0);
        check("mid reset out_data", 64'(out_data), 64'd0);
        rst = 1'b1;
        cyc("post reset idle", 0, 0, '0, 1, 0);
        cyc("post reset idle2", 0, 0, '0, 1, 0);
        cyc("post reset push", 0, 1, 48'h77, 0, 0);
        drain("post reset drain");

        // Stalled consumer: head stable while pushes continue
        cyc("stall first", 0, 1, 48'h300, 0, 0);
        for (int i = 0; i < 10; i++) cyc("stall", 0, 1, WIDTH'(48'h301 + i), 0, 0);
        drain("stall drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
